// File: rtl/day01_pkg.sv
// -----------------------------------------------------------------------------
// day01_pkg
// Shared definitions for the result transmitter: ASCII constants, the FSM
// state encoding and a digit-to-character helper.
// -----------------------------------------------------------------------------
package day01_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NL   = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONVERT = 3'd1,
    S_SKIP    = 3'd2,
    S_EMIT    = 3'd3,
    S_NL      = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  // Map one BCD digit (0..9) onto its ASCII character.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'd0, d};
  endfunction

endpackage

// File: rtl/result_ascii_tx_if.sv
// -----------------------------------------------------------------------------
// result_ascii_tx_if
// Bundles the transmitter's control, result and byte-stream signals.
//   master : the transmitter (drives char_out/char_valid/busy/done)
//   slave  : the environment (drives start, results and char_ready)
// -----------------------------------------------------------------------------
interface result_ascii_tx_if #(
  parameter int DATA_WIDTH = 16
);
  import day01_pkg::*;

  logic                  start;
  logic [DATA_WIDTH-1:0] part1_result;
  logic [DATA_WIDTH-1:0] part2_result;
  logic [7:0]            char_out;
  logic                  char_valid;
  logic                  char_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, part1_result, part2_result, char_ready,
    output char_out, char_valid, busy, done
  );

  modport slave (
    output start, part1_result, part2_result, char_ready,
    input  char_out, char_valid, busy, done
  );

endinterface

// File: rtl/bin2bcd_iter.sv
// -----------------------------------------------------------------------------
// bin2bcd_iter
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
//   clk, rst : clock and asynchronous active-high reset
//   load     : latch bin_in and start a conversion (restarts any in progress)
//   bin_in   : unsigned value to convert
//   bcd_out  : N_DIGITS packed BCD digits, digit 0 in the low nibble
//   done     : high during the cycle whose closing edge performs the final
//              shift, so bcd_out is complete right after that edge
// -----------------------------------------------------------------------------
module bin2bcd_iter
  import day01_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_DIGITS   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   bin_in,
  output logic [4*N_DIGITS-1:0]   bcd_out,
  output logic                    done
);

  localparam int                CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [4*N_DIGITS-1:0] bcd_q, bcd_d, bcd_adj_s;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  run_q, run_d;

  // Add 3 to every digit that is 5 or more, ahead of the shift.
  function automatic logic [4*N_DIGITS-1:0] add3(input logic [4*N_DIGITS-1:0] v);
    logic [4*N_DIGITS-1:0] r;
    r = v;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      else                     r[4*i +: 4] = v[4*i +: 4];
    end
    return r;
  endfunction

  // Next-state for the shift registers and shift counter.
  always_comb begin
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    bcd_adj_s = add3(bcd_q);
    if (load) begin
      bin_d = bin_in;
      bcd_d = {(4*N_DIGITS){1'b0}};
      cnt_d = {CNT_W{1'b0}};
      run_d = 1'b1;
    end else if (run_q) begin
      bcd_d = {bcd_adj_s[4*N_DIGITS-2:0], bin_q[DATA_WIDTH-1]};
      bin_d = {bin_q[DATA_WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) run_d = 1'b0;
      else               run_d = 1'b1;
    end else begin
      run_d = 1'b0;
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= {DATA_WIDTH{1'b0}};
      bcd_q <= {(4*N_DIGITS){1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign bcd_out = bcd_q;
  assign done    = run_q & (cnt_q == LAST);

endmodule

// File: rtl/result_ascii_tx.sv
// -----------------------------------------------------------------------------
// result_ascii_tx
// On a rising edge of start, captures two unsigned results and streams them as
// decimal ASCII without leading zeros: part-1 digits, LF, part-2 digits, LF.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : result_ascii_tx_if.master (start, part1/2_result, char_out,
//              char_valid, char_ready, busy, done)
// -----------------------------------------------------------------------------
module result_ascii_tx
  import day01_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_DIGITS   = 5
) (
  input  logic             clk,
  input  logic             rst,
  result_ascii_tx_if.master bus
);

  localparam int               IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N_DIGITS - 1);

  state_e                state_q, state_d;
  logic                  start_q, start_d;
  logic                  sel_q, sel_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [7:0]            char_out_q, char_out_d;
  logic                  char_valid_q, char_valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] p2_q, p2_d;

  logic                  trig_s, accept_s;
  logic                  conv_load_s, conv_done_s;
  logic [DATA_WIDTH-1:0] conv_val_s;
  logic [4*N_DIGITS-1:0] bcd_s;
  logic [IDX_W-1:0]      idx_m1_s;
  logic [3:0]            digit_s, digit_nxt_s;

  bin2bcd_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_DIGITS   (N_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .load    (conv_load_s),
    .bin_in  (conv_val_s),
    .bcd_out (bcd_s),
    .done    (conv_done_s)
  );

  // Only a fresh rising edge of the sticky start level, and only when idle.
  assign trig_s      = bus.start & ~start_q & ((state_q == S_IDLE) | (state_q == S_DONE));
  assign accept_s    = char_valid_q & bus.char_ready;
  assign idx_m1_s    = idx_q - IDX_W'(1);
  assign digit_s     = 4'(bcd_s >> {idx_q, 2'b00});
  assign digit_nxt_s = 4'(bcd_s >> {idx_m1_s, 2'b00});
  assign start_d     = bus.start;

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
      idx_q        <= IDX_ZERO;
      p2_q         <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
      idx_q        <= idx_d;
      p2_q         <= p2_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (trig_s) state_d = S_CONVERT;
        else        state_d = state_q;
      end
      S_CONVERT: begin
        if (conv_done_s) state_d = S_SKIP;
        else             state_d = S_CONVERT;
      end
      S_SKIP: begin
        if ((digit_s == 4'd0) && (idx_q != IDX_ZERO)) state_d = S_SKIP;
        else                                          state_d = S_EMIT;
      end
      S_EMIT: begin
        if (accept_s && (idx_q == IDX_ZERO)) state_d = S_NL;
        else                                 state_d = S_EMIT;
      end
      S_NL: begin
        if (accept_s) begin
          if (sel_q) state_d = S_DONE;
          else       state_d = S_CONVERT;
        end else begin
          state_d = S_NL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    sel_d        = sel_q;
    busy_d       = busy_q;
    done_d       = done_q;
    char_out_d   = char_out_q;
    char_valid_d = char_valid_q;
    idx_d        = idx_q;
    p2_d         = p2_q;
    conv_load_s  = 1'b0;
    conv_val_s   = bus.part1_result;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Part 1 goes straight into the converter; part 2 is held for later.
        if (trig_s) begin
          sel_d       = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          p2_d        = bus.part2_result;
          conv_load_s = 1'b1;
          conv_val_s  = bus.part1_result;
        end else begin
          busy_d = busy_q;
        end
      end
      S_CONVERT: begin
        if (conv_done_s) idx_d = IDX_TOP;
        else             idx_d = idx_q;
      end
      S_SKIP: begin
        if ((digit_s == 4'd0) && (idx_q != IDX_ZERO)) begin
          idx_d = idx_m1_s;
        end else begin
          char_out_d   = digit_to_ascii(digit_s);
          char_valid_d = 1'b1;
        end
      end
      S_EMIT: begin
        if (accept_s) begin
          if (idx_q != IDX_ZERO) begin
            idx_d      = idx_m1_s;
            char_out_d = digit_to_ascii(digit_nxt_s);
          end else begin
            char_out_d = ASCII_NL;
          end
        end else begin
          char_out_d = char_out_q;
        end
      end
      S_NL: begin
        if (accept_s) begin
          char_valid_d = 1'b0;
          if (!sel_q) begin
            sel_d       = 1'b1;
            conv_load_s = 1'b1;
            conv_val_s  = p2_q;
          end else begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else begin
          char_valid_d = char_valid_q;
        end
      end
      default: begin
        char_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.char_out   = char_out_q;
  assign bus.char_valid = char_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: doc/result_ascii_tx.md
# result_ascii_tx

Transmit-side counterpart to the puzzle input decoder. When the solver core signals completion, it captures both binary results and converts each one to unsigned decimal ASCII. It then streams the text out as bytes over a valid/ready handshake, for example to a UART transmitter. Output format per run: part-1 digits, 0x0A, part-2 digits, 0x0A. There are no leading zeros, and a zero value is sent as "0".

## Interface
- `DATA_WIDTH`, 16, width of each result input.
- `N_DIGITS`, 5, number of BCD digits; must satisfy 10^N_DIGITS > 2^DATA_WIDTH - 1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: a rising edge triggers one transmission; driven from the core's `done`, which is a sticky level.
- `part1_result` input DATA_WIDTH: first value; captured on the trigger.
- `part2_result` input DATA_WIDTH: second value; captured on the trigger.
- `char_out` output 8: ASCII byte.
- `char_valid` output 1: `char_out` holds a byte.
- `char_ready` input 1: downstream accepts the byte this cycle.
- `busy` output 1: high from the trigger until the last byte is accepted.
- `done` output 1: high after the final newline is accepted; stays high until the next trigger or reset.

## Operation
- Trigger detection:
  - `start_q` registers `start` every cycle.
  - trigger = `start & ~start_q & (state == S_IDLE || state == S_DONE)`.
  - A held-high `start` causes exactly one run.
  - An edge of `start` while `busy` is ignored.
- States and transitions:
  - **S_IDLE.** On trigger: capture both results, set `sel` = 0, set `busy` = 1, go to S_CONVERT.
  - **S_DONE.** `done` = 1. On trigger: clear `done`, then proceed exactly as from S_IDLE.
  - **S_CONVERT.** Iterative double-dabble on the selected value: one shift per cycle, exactly DATA_WIDTH cycles. Then set `idx` = N_DIGITS-1 and go to S_SKIP.
  - **S_SKIP.** While `bcd[idx]` == 0 and `idx` != 0, decrement `idx` (one digit per cycle). Otherwise load `char_out` = 0x30 + `bcd[idx]`, set `char_valid` = 1, and go to S_EMIT.
  - **S_EMIT.** On `char_valid & char_ready`:
    - if `idx` != 0: decrement `idx` and load the next digit.
    - else: load 0x0A and go to S_NL.
  - **S_NL.** On accept:
    - if `sel` == 0: set `sel` = 1, drop `char_valid`, go to S_CONVERT.
    - else: drop `char_valid`, clear `busy`, set `done`, go to S_DONE.
- Handshake rules:
  - Transfer occurs on any edge where `char_valid & char_ready`.
  - While `char_valid & ~char_ready`, `char_out` is held stable and `char_valid` stays high.
  - No byte is dropped or repeated.
  - `char_valid` never depends combinationally on `char_ready`.
- Arithmetic:
  - The BCD register is 4·N_DIGITS bits.
  - Each digit gets +3 when ≥5 before every shift.
  - All values are unsigned. The maximum input (2^DATA_WIDTH − 1) converts exactly.

## Timing
- Reset values: `char_out` = 0x00, `char_valid` = 0, `busy` = 0, `done` = 0, `start_q` = 0, state = S_IDLE.
- Asserting `rst` mid-run clears everything asynchronously. The byte in flight is abandoned, and no partial-run state survives.
- Let the trigger edge be T. With z1 = number of leading zero digits skipped for part 1:
  - S_CONVERT occupies T+1 … T+DATA_WIDTH.
  - S_SKIP spends z1 cycles skipping; the first digit is loaded on the following edge.
  - First `char_valid` is therefore visible after edge T + DATA_WIDTH + z1 + 1.
- Per-byte throughput is one byte per cycle while `char_ready` stays high.
- Between the part-1 newline and the first part-2 digit:
  - `char_valid` is low for DATA_WIDTH + z2 + 1 cycles.
  - z2 = number of leading zero digits skipped for part 2.
- `busy` falls and `done` rises on the same edge that accepts the final 0x0A.

## Structure
- Shared package `day01_pkg` holds:
  - ASCII constants `ASCII_ZERO` = 0x30 and `ASCII_NL` = 0x0A.
  - State encodings S_IDLE, S_CONVERT, S_SKIP, S_EMIT, S_NL, S_DONE.
- One sub-module, `bin2bcd_iter`:
  - Interface: load/start, DATA_WIDTH-bit input, N_DIGITS-digit output, a done pulse after DATA_WIDTH cycles.
  - Reset: the same `clk` and async `rst`.
  - The top FSM sequences it twice per run.

## Test plan
- **Basic stream.** part1 = 1234, part2 = 5678, `char_ready` tied high, one `start` edge → bytes 0x31 0x32 0x33 0x34 0x0A 0x35 0x36 0x37 0x38 0x0A. `done` = 1 and `busy` = 0 after the last byte.
- **Zero and maximum.** part1 = 0, part2 = 65535 → "0\n65535\n" (0x30 0x0A 0x36 0x35 0x35 0x33 0x35 0x0A). First `char_valid` appears 1 + 16 + 4 cycles after the trigger.
- **Backpressure.** part1 = 907, part2 = 1, `char_ready` pattern 1,0,0,1,0,1… → exactly "907\n1\n". `char_out` is constant during every stall.
- **Level start.** `start` held high for 200 cycles with part1 = 42, part2 = 7 → exactly one "42\n7\n". A second rising edge after `done` → one more identical stream, and `done` drops on the trigger.
- **Reset mid-run.** `rst` asserted after 2 of the bytes of "1234\n…" are accepted → `char_valid`, `busy`, `done` go low immediately. A fresh `start` edge after release → the complete stream from the first digit.
- **Ignored trigger.** A `start` pulse while `busy` → no restart, and the output stream is unchanged.
